// File: rtl/intr_pkg.sv
// ============================================================================
// Module   : intr_pkg
// Purpose  : Shared state encoding for the interrupt pulse arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_GAP      = 2'd2,
    ST_WAIT_ACK = 2'd3
  } intr_state_t;

endpackage

`default_nettype wire

// File: rtl/intr_edge_chan.sv
// ============================================================================
// Module   : intr_edge_chan
// Purpose  : One request channel: rising-edge detect, pending and sticky
//            overflow flags. A new edge wins over a same-cycle grant clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module intr_edge_chan
  import intr_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic press,
  input  logic mask,
  input  logic clr,
  output logic pending,
  output logic overflow
);

  logic press_q, press_d;
  logic pending_q, pending_d;
  logic overflow_q, overflow_d;
  logic set_req;

  always_comb begin
    press_d    = press;
    set_req    = press & ~press_q & mask;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (set_req) begin
      pending_d = 1'b1;
      // Only a genuinely lost event counts; an edge racing its own grant is kept.
      if (pending_q && !clr) overflow_d = 1'b1;
    end else if (clr) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      press_q    <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      press_q    <= press_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: rtl/intr_pulse_arbiter.sv
// ============================================================================
// Module   : intr_pulse_arbiter
// Purpose  : Fixed-priority arbiter turning latched request edges into
//            PULSE_LEN-cycle interrupt pulses tagged with a channel ID.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module intr_pulse_arbiter
  import intr_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int PULSE_LEN = 6,
  parameter int ACK_MODE  = 0,
  parameter int ID_W      = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] press,
  input  logic [NUM_CH-1:0] mask,
  input  logic              intr_ack,
  output logic              interrupt,
  output logic [ID_W-1:0]   intr_id,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overflow
);

  localparam int                CNT_W    = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  intr_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              interrupt_q, interrupt_d;

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] clr;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    intr_edge_chan u_chan (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .press    (press[i]),
      .mask     (mask[i]),
      .clr      (clr[i]),
      .pending  (pending[i]),
      .overflow (overflow[i])
    );
  end

  assign eligible = pending & mask;

  // Scan from the top so the lowest eligible index is the last one written.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_LOAD;
          id_d    = grant_idx;
          clr     = NUM_CH'(1) << grant_idx;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) state_d = (ACK_MODE != 0) ? ST_WAIT_ACK : ST_GAP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_GAP:      state_d = ST_IDLE;
      ST_WAIT_ACK: if (intr_ack) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    interrupt_d = (state_d == ST_PULSE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      id_q        <= '0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign interrupt = interrupt_q;
  assign intr_id   = id_q;

endmodule

`default_nettype wire

// File: tb/tb_intr_pulse_arbiter.sv
// ============================================================================
// Module   : tb_intr_pulse_arbiter
// Purpose  : Self-checking bench: auto re-arm instance with a pulse scoreboard
//            plus an acknowledge-mode instance exercised directly.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intr_pulse_arbiter;

  localparam int NUM_CH    = 4;
  localparam int PULSE_LEN = 6;
  localparam int ID_W      = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n0, rst_n1;
  logic [NUM_CH-1:0] p0, m0, p1, m1;
  logic              ack0, ack1;
  logic              int0, int1;
  logic [ID_W-1:0]   id0, id1;
  logic [NUM_CH-1:0] pend0, ovf0, pend1, ovf1;

  intr_pulse_arbiter #(.NUM_CH(NUM_CH), .PULSE_LEN(PULSE_LEN), .ACK_MODE(0)) dut0 (
    .CLK(clk), .RST_N(rst_n0), .press(p0), .mask(m0), .intr_ack(ack0),
    .interrupt(int0), .intr_id(id0), .pending(pend0), .overflow(ovf0)
  );

  intr_pulse_arbiter #(.NUM_CH(NUM_CH), .PULSE_LEN(PULSE_LEN), .ACK_MODE(1)) dut1 (
    .CLK(clk), .RST_N(rst_n1), .press(p1), .mask(m1), .intr_ack(ack1),
    .interrupt(int1), .intr_id(id1), .pending(pend1), .overflow(ovf1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard: expected channel IDs of dut0 pulses, in service order.
  int              sb_q[$];
  logic            in_pulse = 1'b0;
  int              width    = 0;
  logic [ID_W-1:0] cur_id   = '0;
  int              exp_id;
  int              highs;

  always @(negedge clk) begin
    if (int0 === 1'b1) begin
      if (!in_pulse) begin
        in_pulse = 1'b1;
        width    = 0;
        cur_id   = id0;
      end else begin
        chk("mon_id_stable", id0, cur_id);
      end
      width++;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      chk("mon_expected", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        exp_id = sb_q.pop_front();
        chk("mon_id", cur_id, exp_id);
        chk("mon_len", width, PULSE_LEN);
      end
    end
  end

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    p0 = '0; p1 = '0; m0 = '1; m1 = '1; ack0 = 1'b0; ack1 = 1'b0;
    ticks(3);
    chk("rst_int0", int0, 0);   chk("rst_id0", id0, 0);
    chk("rst_pend0", pend0, 0); chk("rst_ovf0", ovf0, 0);
    chk("rst_int1", int1, 0);   chk("rst_id1", id1, 0);
    chk("rst_pend1", pend1, 0); chk("rst_ovf1", ovf1, 0);
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    tick();

    // Single press on ch2
    sb_q.push_back(2);
    p0 = 4'b0100; tick();
    chk("s1_pend_set", pend0, 4'b0100);
    chk("s1_int_lat", int0, 0);
    tick();
    chk("s1_int_on", int0, 1);
    chk("s1_id", id0, 2);
    chk("s1_pend_clr", pend0, 0);
    ticks(5);
    chk("s1_int_last", int0, 1);
    tick();
    chk("s1_int_off", int0, 0);
    p0 = '0; ticks(4);

    // ch0 and ch3 together: priority, gap, idle, second pulse
    sb_q.push_back(0); sb_q.push_back(3);
    p0 = 4'b1001; tick();
    chk("s2_pend_both", pend0, 4'b1001);
    tick();
    chk("s2_int_on", int0, 1);
    chk("s2_id0", id0, 0);
    chk("s2_pend_q", pend0, 4'b1000);
    ticks(5);
    chk("s2_int_last", int0, 1);
    tick();
    chk("s2_gap", int0, 0);
    p0 = '0; tick();
    chk("s2_idle", int0, 0);
    tick();
    chk("s2_int_on3", int0, 1);
    chk("s2_id3", id0, 3);
    chk("s2_pend_empty", pend0, 0);
    ticks(10);

    // Held press gives one pulse; re-edge during a pulse re-latches cleanly
    sb_q.push_back(1);
    p0 = 4'b0010; ticks(50);
    chk("s3_held_pend", pend0, 0);
    chk("s3_held_ovf", ovf0, 0);
    chk("s3_held_int", int0, 0);
    p0 = '0; tick();
    sb_q.push_back(1);
    p0 = 4'b0010; tick();
    chk("s3_pend_set", pend0, 4'b0010);
    tick();
    chk("s3_int_on", int0, 1);
    chk("s3_id", id0, 1);
    tick();
    p0 = '0; tick();
    sb_q.push_back(1);
    p0 = 4'b0010; tick();
    chk("s3_repend", pend0[1], 1);
    chk("s3_no_ovf", ovf0[1], 0);
    chk("s3_int_mid", int0, 1);
    ticks(20);
    p0 = '0; tick();

    // Overflow while pending, masked hold, then release by unmasking
    sb_q.push_back(0);
    p0 = 4'b0001; ticks(2);
    p0 = 4'b0011; tick();
    p0 = 4'b0001; tick();
    p0 = 4'b0011; tick();
    chk("s4_ovf_set", ovf0, 4'b0010);
    chk("s4_pend1", pend0[1], 1);
    m0 = 4'b1101; ticks(12);
    chk("s4_masked_pend", pend0, 4'b0010);
    chk("s4_masked_ovf", ovf0, 4'b0010);
    chk("s4_masked_int", int0, 0);
    sb_q.push_back(1);
    m0 = '1; tick();
    chk("s4_unmask_int", int0, 1);
    chk("s4_unmask_id", id0, 1);
    chk("s4_unmask_pend", pend0, 0);
    ticks(10);
    chk("s4_ovf_sticky", ovf0, 4'b0010);
    p0 = '0; tick();

    // Acknowledge mode: hold after pulse, queued ch2 waits for ack
    p1 = 4'b0001; ticks(2);
    p1 = 4'b0101; tick();
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    chk("a1_ack_ignored", int1, 1);
    chk("a1_pend2", pend1, 4'b0100);
    ticks(3);
    chk("a1_int_last", int1, 1);
    tick();
    chk("a1_wait_int", int1, 0);
    chk("a1_wait_id", id1, 0);
    ticks(5);
    chk("a1_hold_int", int1, 0);
    chk("a1_hold_id", id1, 0);
    chk("a1_hold_pend", pend1, 4'b0100);
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    chk("a1_idle_int", int1, 0);
    tick();
    chk("a1_ch2_int", int1, 1);
    chk("a1_ch2_id", id1, 2);
    chk("a1_ch2_pend", pend1, 0);
    ticks(6);
    chk("a1_ch2_wait", int1, 0);
    chk("a1_ch2_hold", id1, 2);
    ack1 = 1'b1; tick(); ack1 = 1'b0;
    p1 = '0; ticks(3);
    chk("a1_done", int1, 0);

    // Reset mid-pulse with pending and overflow present
    p1 = 4'b0010; ticks(2);
    p1 = 4'b1010; tick();
    p1 = 4'b0010; tick();
    p1 = 4'b1010; tick();
    chk("a2_pre_ovf", ovf1, 4'b1000);
    chk("a2_pre_int", int1, 1);
    rst_n1 = 1'b0; p1 = '0; tick();
    chk("a2_rst_int", int1, 0);
    chk("a2_rst_pend", pend1, 0);
    chk("a2_rst_ovf", ovf1, 0);
    chk("a2_rst_id", id1, 0);
    rst_n1 = 1'b1;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (int1 === 1'b1) highs++;
    end
    chk("a2_no_pulse", highs, 0);

    chk("sb_empty", sb_q.size(), 0);
    chk("mon_idle", in_pulse, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
